// File: rtl/reg_tag_pipeline.sv
// reg_tag_pipeline
//   Carries register-tag control fields from decode through the EX, MEM and
//   WB stages of a 5-stage MIPS pipeline. Feeds the forwarding unit, detects
//   load-use hazards and data-memory freezes, and counts stall cycles.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | pipeline advancing (flush / fetch-miss bubbles included)
//   MEMWAIT  | MEM-stage load/store waiting on dhit; EX and MEM frozen
//   LUBUBBLE | load in EX feeds decode; one bubble inserted into EX
//
//   The state is a classification of the current cycle, not stored history:
//   MEMWAIT lasts as long as dhit stays low, and when it ends the held EX
//   entry is re-examined for a load-use hazard in the same cycle.
//
// Ports:
//   CLK, nRST                      clock (rising edge), async active-low reset
//   rs_id, rt_id, regdst_id        decode-stage register tags
//   regwr_id, memrd_id, memwr_id   decode-stage write / load / store flags
//   valid_id                       decode-stage instruction valid
//   ihit, dhit                     fetch complete, MEM data access complete
//   flush_ex                       taken branch/jump in EX; squash decode
//   Rs_ex, Rt_ex                   EX-stage source tags
//   RegDst_mem, RegWr_mem          MEM-stage destination tag / write enable
//   RegDst_wb, RegWr_wb            WB-stage destination tag / write enable
//   stall_id                       hold PC and IF/ID this cycle
//   mem_wait                       pipeline frozen on data memory
//   stall_cycles                   saturating count of stall_id cycles
module reg_tag_pipeline #(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [REGW-1:0] rs_id,
    input  logic [REGW-1:0] rt_id,
    input  logic [REGW-1:0] regdst_id,
    input  logic            regwr_id,
    input  logic            memrd_id,
    input  logic            memwr_id,
    input  logic            valid_id,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            flush_ex,
    output logic [REGW-1:0] Rs_ex,
    output logic [REGW-1:0] Rt_ex,
    output logic [REGW-1:0] RegDst_mem,
    output logic            RegWr_mem,
    output logic [REGW-1:0] RegDst_wb,
    output logic            RegWr_wb,
    output logic            stall_id,
    output logic            mem_wait,
    output logic [CNTW-1:0] stall_cycles
);

    typedef struct packed {
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] dst;
        logic            wr;
        logic            memrd;
        logic            memwr;
        logic            valid;
    } ex_t;

    typedef struct packed {
        logic [REGW-1:0] dst;
        logic            wr;
        logic            memrd;
        logic            memwr;
        logic            valid;
    } mem_t;

    typedef struct packed {
        logic [REGW-1:0] dst;
        logic            wr;
        logic            valid;
    } wb_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEMWAIT  = 2'd1,
        LUBUBBLE = 2'd2
    } state_t;

    ex_t    ex_q,  ex_nxt;
    mem_t   mem_q, mem_nxt;
    wb_t    wb_q,  wb_nxt;
    state_t state;

    logic            load_use;
    logic            ex_bubble;
    logic [CNTW-1:0] cnt_q;

    // Hazard detection
    always_comb begin
        mem_wait = mem_q.valid & (mem_q.memrd | mem_q.memwr) & ~dhit;
        load_use = ex_q.valid & ex_q.memrd & ex_q.wr & (ex_q.dst != '0) &
                   valid_id & ((ex_q.dst == rs_id) | (ex_q.dst == rt_id));
        // The ~ihit term is gated so every output reads 0 while reset is held.
        stall_id = nRST & (mem_wait | load_use | ~ihit);
    end

    always_comb begin
        state = RUN;
        if (mem_wait) begin
            state = MEMWAIT;
        end else if (load_use) begin
            state = LUBUBBLE;
        end
    end

    // Next-stage contents; flush and fetch miss only bubble EX, so they
    // share the RUN path with the normal advance.
    always_comb begin
        ex_nxt    = ex_q;
        mem_nxt   = mem_q;
        wb_nxt    = wb_q;
        ex_bubble = flush_ex | ~ihit;

        case (state)
            MEMWAIT: begin
                // Freeze EX and MEM; a pending flush stays in EX until release.
                ex_nxt  = ex_q;
                mem_nxt = mem_q;
                wb_nxt  = '0;
            end
            LUBUBBLE, RUN: begin
                mem_nxt.dst   = ex_q.dst;
                mem_nxt.wr    = ex_q.wr;
                mem_nxt.memrd = ex_q.memrd;
                mem_nxt.memwr = ex_q.memwr;
                mem_nxt.valid = ex_q.valid;

                wb_nxt.dst    = mem_q.dst;
                wb_nxt.wr     = mem_q.wr;
                wb_nxt.valid  = mem_q.valid;

                if (state == LUBUBBLE || ex_bubble) begin
                    ex_nxt = '0;
                end else begin
                    ex_nxt.rs    = rs_id;
                    ex_nxt.rt    = rt_id;
                    ex_nxt.dst   = regdst_id;
                    ex_nxt.wr    = regwr_id & valid_id;
                    ex_nxt.memrd = memrd_id;
                    ex_nxt.memwr = memwr_id;
                    ex_nxt.valid = valid_id;
                end
            end
            default: begin
                ex_nxt  = '0;
                mem_nxt = '0;
                wb_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_nxt;
            mem_q <= mem_nxt;
            wb_q  <= wb_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (stall_id && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

    // Write enables are qualified by valid; invalid entries never carry wr=1,
    // so this only keeps the valid bits meaningful at the outputs.
    assign Rs_ex        = ex_q.rs;
    assign Rt_ex        = ex_q.rt;
    assign RegDst_mem   = mem_q.dst;
    assign RegWr_mem    = mem_q.wr & mem_q.valid;
    assign RegDst_wb    = wb_q.dst;
    assign RegWr_wb     = wb_q.wr & wb_q.valid;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_reg_tag_pipeline.sv
module tb_reg_tag_pipeline;
    localparam int REGW = 5;
    localparam int CNTW = 16;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [REGW-1:0] rs_id, rt_id, regdst_id;
    logic            regwr_id, memrd_id, memwr_id, valid_id;
    logic            ihit, dhit, flush_ex;
    logic [REGW-1:0] Rs_ex, Rt_ex, RegDst_mem, RegDst_wb;
    logic            RegWr_mem, RegWr_wb, stall_id, mem_wait;
    logic [CNTW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sc = 0;
    int wb_q[$];

    reg_tag_pipeline #(.REGW(REGW), .CNTW(CNTW)) dut (
        .CLK(CLK), .nRST(nRST),
        .rs_id(rs_id), .rt_id(rt_id), .regdst_id(regdst_id),
        .regwr_id(regwr_id), .memrd_id(memrd_id), .memwr_id(memwr_id),
        .valid_id(valid_id), .ihit(ihit), .dhit(dhit), .flush_ex(flush_ex),
        .Rs_ex(Rs_ex), .Rt_ex(Rt_ex), .RegDst_mem(RegDst_mem),
        .RegWr_mem(RegWr_mem), .RegDst_wb(RegDst_wb), .RegWr_wb(RegWr_wb),
        .stall_id(stall_id), .mem_wait(mem_wait), .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input int dst,
                          input logic wr, input logic ld, input logic st, input logic v);
        rs_id     = REGW'(rs);
        rt_id     = REGW'(rt);
        regdst_id = REGW'(dst);
        regwr_id  = wr;
        memrd_id  = ld;
        memwr_id  = st;
        valid_id  = v;
    endtask

    // Writeback scoreboard: each retiring register write must match the
    // oldest expected destination.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && RegWr_wb === 1'b1) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 32'(RegWr_wb), 32'd0);
            else                  chk("wb_dst", 32'(RegDst_wb), 32'(wb_q.pop_front()));
        end
    end

    initial begin
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b1; flush_ex = 1'b0;
        set_id(7, 8, 9, 1'b1, 1'b1, 1'b0, 1'b1);
        #3;
        chk("rst_rs_ex",    32'(Rs_ex), 0);
        chk("rst_wr_wb",    32'(RegWr_wb), 0);
        chk("rst_stall_id", 32'(stall_id), 0);
        chk("rst_cnt",      32'(stall_cycles), 0);
        @(posedge CLK); @(posedge CLK); #2;
        nRST = 1'b1; ihit = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0);
        step();

        // normal flow: add $3, $1, $2
        set_id(1, 2, 3, 1, 0, 0, 1); wb_q.push_back(3);
        step(); set_id(0, 0, 0, 0, 0, 0, 0);
        chk("nf_rs_ex", 32'(Rs_ex), 1);
        chk("nf_rt_ex", 32'(Rt_ex), 2);
        step();
        chk("nf_dst_mem", 32'(RegDst_mem), 3);
        chk("nf_wr_mem",  32'(RegWr_mem), 1);
        step();
        chk("nf_dst_wb", 32'(RegDst_wb), 3);
        chk("nf_wr_wb",  32'(RegWr_wb), 1);
        repeat (3) step();

        // load-use: lw $5 then use of $5
        set_id(4, 0, 5, 1, 1, 0, 1); wb_q.push_back(5);
        step();
        set_id(5, 6, 7, 1, 0, 0, 1);
        #1 chk("lu_stall", 32'(stall_id), 1);
        step(); exp_sc++;
        chk("lu_bubble_rs", 32'(Rs_ex), 0);
        chk("lu_ld_in_mem", 32'(RegDst_mem), 5);
        chk("lu_stall_once", 32'(stall_id), 0);
        chk("lu_cnt", 32'(stall_cycles), 32'(exp_sc));
        wb_q.push_back(7);
        step(); set_id(0, 0, 0, 0, 0, 0, 0);
        chk("lu_dep_rs", 32'(Rs_ex), 5);
        chk("lu_dep_rt", 32'(Rt_ex), 6);
        chk("lu_ld_in_wb", 32'(RegDst_wb), 5);
        repeat (3) step();

        // load to $0 followed by a $0 reader: no stall
        set_id(4, 0, 0, 1, 1, 0, 1); wb_q.push_back(0);
        step();
        set_id(0, 9, 8, 1, 0, 0, 1); wb_q.push_back(8);
        #1 chk("z_no_stall", 32'(stall_id), 0);
        step(); set_id(0, 0, 0, 0, 0, 0, 0);
        chk("z_rt_ex",  32'(Rt_ex), 9);
        chk("z_wr_mem", 32'(RegWr_mem), 1);
        chk("z_dst_mem", 32'(RegDst_mem), 0);
        repeat (4) step();

        // memory wait on a store, with flush asserted during the freeze
        set_id(1, 1, 18, 1, 0, 0, 1); wb_q.push_back(18);
        step();
        set_id(10, 11, 11, 0, 0, 1, 1);
        step();
        set_id(12, 13, 14, 1, 0, 0, 1); wb_q.push_back(14);
        step();
        dhit = 1'b0; flush_ex = 1'b1;
        set_id(15, 16, 17, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("mw_mem_wait", 32'(mem_wait), 1);
            chk("mw_stall", 32'(stall_id), 1);
            step(); exp_sc++;
            chk("mw_rs_held",  32'(Rs_ex), 12);
            chk("mw_dst_held", 32'(RegDst_mem), 11);
            chk("mw_wb_bubble", 32'(RegWr_wb), 0);
        end
        chk("mw_cnt", 32'(stall_cycles), 32'(exp_sc));
        dhit = 1'b1;
        #1 chk("mw_release_stall", 32'(stall_id), 0);
        step(); flush_ex = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0);
        chk("mw_flush_rs",  32'(Rs_ex), 0);
        chk("mw_adv_mem",   32'(RegDst_mem), 14);
        chk("mw_adv_wb",    32'(RegDst_wb), 11);
        chk("mw_adv_wb_wr", 32'(RegWr_wb), 0);
        repeat (4) step();

        // flush and load-use together: one bubble only
        set_id(2, 0, 20, 1, 1, 0, 1); wb_q.push_back(20);
        step();
        set_id(20, 3, 21, 1, 0, 0, 1); flush_ex = 1'b1;
        #1 chk("fl_stall", 32'(stall_id), 1);
        step(); exp_sc++; flush_ex = 1'b0;
        chk("fl_bubble", 32'(Rs_ex), 0);
        chk("fl_ld_mem", 32'(RegDst_mem), 20);
        #1 chk("fl_no_second", 32'(stall_id), 0);
        wb_q.push_back(21);
        step(); set_id(0, 0, 0, 0, 0, 0, 0);
        chk("fl_dep_rs", 32'(Rs_ex), 20);
        chk("fl_cnt", 32'(stall_cycles), 32'(exp_sc));
        repeat (4) step();

        // fetch miss bubbles EX; then saturate the counter
        set_id(3, 4, 0, 0, 0, 0, 1); ihit = 1'b0;
        #1 chk("im_stall", 32'(stall_id), 1);
        step(); exp_sc++;
        chk("im_bubble", 32'(Rs_ex), 0);
        chk("im_cnt", 32'(stall_cycles), 32'(exp_sc));
        repeat (65535 - exp_sc) step();
        chk("sat_reach", 32'(stall_cycles), 32'hFFFF);
        repeat (3) step();
        chk("sat_hold", 32'(stall_cycles), 32'hFFFF);
        chk("sb_drain", 32'(wb_q.size()), 0);

        // reset mid-run
        ihit = 1'b1;
        set_id(1, 2, 3, 1, 0, 0, 1); step();
        set_id(4, 5, 6, 1, 0, 0, 1); step();
        set_id(7, 8, 9, 1, 0, 0, 1); step();
        nRST = 1'b0; ihit = 1'b0; wb_q.delete();
        #1;
        chk("mr_rs_ex",   32'(Rs_ex), 0);
        chk("mr_dst_mem", 32'(RegDst_mem), 0);
        chk("mr_wr_wb",   32'(RegWr_wb), 0);
        chk("mr_stall",   32'(stall_id), 0);
        chk("mr_cnt",     32'(stall_cycles), 0);
        @(posedge CLK); #2;
        nRST = 1'b1; ihit = 1'b1; set_id(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("mr_cnt_after", 32'(stall_cycles), 0);
        chk("mr_wr_mem_after", 32'(RegWr_mem), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
